// File: rtl/servo_pkg.sv
// servo_pkg: shared types, default timing constants and the pulse-width
// helper for the servo PWM generator.
package servo_pkg;

    typedef logic [7:0]  pos_t;
    typedef logic [18:0] cyc_t;
    typedef logic [16:0] width_t;

    typedef enum logic {
        S_LOW   = 1'b0,
        S_PULSE = 1'b1
    } servo_state_t;

    // Timing for the 25 MHz board clock at 50 Hz, 1000..2000 us.
    localparam int unsigned FRAME_CYC = 500_000;
    localparam int unsigned MIN_CYC   = 25_000;
    localparam int unsigned MAX_CYC   = 50_000;
    localparam int unsigned STEP_CYC  = (MAX_CYC - MIN_CYC) / 255;

    // High time in clock cycles for a position: min + pos*step.
    // The 8x8 product fits 16 bits; the sum is carried in 17 bits.
    function automatic width_t calc_width(
        input pos_t   pos,
        input width_t min_cyc,
        input pos_t   step_cyc
    );
        logic [15:0] prod;
        prod = 16'(pos) * 16'(step_cyc);
        return min_cyc + width_t'(prod);
    endfunction

endpackage

// File: rtl/servo_slew_step.sv
// servo_slew_step: combinational limiter that moves the current position
// toward a target by at most STEP, landing exactly on the target when closer.
module servo_slew_step
    import servo_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic [7:0] cur,
    input  logic [7:0] target,
    output logic [7:0] nxt
);

    localparam pos_t STEP_P = pos_t'(STEP);

    pos_t diff;

    // Clamp the step so the result never overshoots or wraps.
    always_comb begin
        nxt  = target;
        diff = '0;
        if (target > cur) begin
            diff = target - cur;
            if (diff > STEP_P) begin
                nxt = cur + STEP_P;
            end
        end else begin
            diff = cur - target;
            if (diff > STEP_P) begin
                nxt = cur - STEP_P;
            end
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: 50 Hz hobby-servo pulse generator with a one-entry
// valid/ready command register that is applied only at frame boundaries.
// Optional build macro SERVO_SLEW_EN limits the per-frame position change.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 25_000_000,
    parameter int unsigned FRAME_HZ  = 50,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned RESET_POS = 128
`ifdef SERVO_SLEW_EN
    ,
    parameter int unsigned SLEW_STEP = 4
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] pos_data,
    input  logic       pos_valid,
    output logic       pos_ready,
    output logic       servo_pin,
    output logic       frame_start,
    output logic [7:0] active_pos
);

    localparam int unsigned FRAME_N = CLK_HZ / FRAME_HZ;
    localparam int unsigned MIN_N   = CLK_HZ / 1_000_000 * MIN_US;
    localparam int unsigned MAX_N   = CLK_HZ / 1_000_000 * MAX_US;
    localparam int unsigned STEP_N  = (MAX_N - MIN_N) / 255;

    localparam cyc_t   FRAME_LAST = cyc_t'(FRAME_N - 1);
    localparam width_t MIN_W      = width_t'(MIN_N);
    localparam pos_t   STEP_W     = pos_t'(STEP_N);
    localparam pos_t   RESET_P    = pos_t'(RESET_POS);
    localparam width_t RESET_W    = calc_width(RESET_P, MIN_W, STEP_W);

    cyc_t         cnt;
    logic         boot_q;
    pos_t         pend_q;
    logic         pend_full;
    logic         en_q;
    logic         en_nxt;
    width_t       width_q;
    width_t       width_nxt;
    cyc_t         pulse_last;
    pos_t         act_nxt;
    logic         boundary;
    logic         xfer;
    servo_state_t state;

`ifdef SERVO_SLEW_EN
    pos_t target_q;
    pos_t tgt_nxt;
    pos_t slew_pos;

    servo_slew_step #(
        .STEP(SLEW_STEP)
    ) u_slew (
        .cur   (active_pos),
        .target(tgt_nxt),
        .nxt   (slew_pos)
    );
`endif

    // boot_q makes the first edge after reset release act as a frame
    // boundary, so counter value 0 (and the first pulse) is the first
    // cycle after release while the counter itself still resets to 0.
    assign boundary   = boot_q || (cnt == FRAME_LAST);
    assign xfer       = pos_valid && !pend_full;
    assign pos_ready  = ~pend_full;
    assign en_nxt     = boundary ? en : en_q;
    assign pulse_last = cyc_t'(width_q) - cyc_t'(1);

    // Next frame position and width, evaluated from pre-edge pending state.
    always_comb begin
`ifdef SERVO_SLEW_EN
        tgt_nxt = pend_full ? pend_q : target_q;
        act_nxt = slew_pos;
`else
        act_nxt = pend_full ? pend_q : active_pos;
`endif
        width_nxt = calc_width(act_nxt, MIN_W, STEP_W);
    end

    // Frame counter: 0..FRAME_N-1, restarting on every boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            boot_q <= 1'b1;
        end else begin
            boot_q <= 1'b0;
            if (boundary) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + cyc_t'(1);
            end
        end
    end

    // One-entry command register; a boundary drains it, a transfer fills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            pend_full <= 1'b0;
        end else if (xfer) begin
            pend_q    <= pos_data;
            pend_full <= 1'b1;
        end else if (boundary) begin
            pend_full <= 1'b0;
        end
    end

    // Per-frame settings latched at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_pos <= RESET_P;
            width_q    <= RESET_W;
            en_q       <= 1'b0;
`ifdef SERVO_SLEW_EN
            target_q   <= RESET_P;
`endif
        end else if (boundary) begin
            active_pos <= act_nxt;
            width_q    <= width_nxt;
            en_q       <= en_nxt;
`ifdef SERVO_SLEW_EN
            target_q   <= tgt_nxt;
`endif
        end
    end

    // Pulse FSM with registered pin and frame_start outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOW;
            servo_pin   <= 1'b0;
            frame_start <= 1'b0;
        end else if (boundary) begin
            frame_start <= 1'b1;
            if (en_nxt) begin
                state     <= S_PULSE;
                servo_pin <= 1'b1;
            end else begin
                state     <= S_LOW;
                servo_pin <= 1'b0;
            end
        end else begin
            frame_start <= 1'b0;
            case (state)
                S_PULSE: begin
                    if (cnt == pulse_last) begin
                        state     <= S_LOW;
                        servo_pin <= 1'b0;
                    end
                end
                S_LOW: begin
                    servo_pin <= 1'b0;
                end
                default: begin
                    state     <= S_LOW;
                    servo_pin <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with a scaled-down clock:
// 1 MHz, 500 Hz frames (2000 cycles), 300..1065 cycles, step 3.
// Widths: pos128=684, pos0=300, pos255=1065, pos10=330, pos200=900, pos140=720.
module tb_servo_pwm_gen;

    localparam int unsigned FRAME = 2000;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       en        = 1'b1;
    logic [7:0] pos_data  = 8'd0;
    logic       pos_valid = 1'b0;
    logic       pos_ready;
    logic       servo_pin;
    logic       frame_start;
    logic [7:0] active_pos;

    int checks = 0;
    int errors = 0;

    servo_pwm_gen #(
        .CLK_HZ   (1_000_000),
        .FRAME_HZ (500),
        .MIN_US   (300),
        .MAX_US   (1065),
        .RESET_POS(128)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pos_data   (pos_data),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .servo_pin  (servo_pin),
        .frame_start(frame_start),
        .active_pos (active_pos)
    );

    always #5 clk = ~clk;

    // Advance at least one cycle, then stop on the next frame_start negedge.
    task automatic sync_frame();
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 3 * FRAME);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL sync_frame: frame_start=%b want 1 within %0d cycles", frame_start, 3 * FRAME);
        end
    endtask

    // Called on a frame_start negedge; counts high cycles and frame length.
    task automatic measure(output int unsigned high, output int unsigned len);
        high = 0;
        len  = 0;
        do begin
            if (servo_pin === 1'b1) high++;
            len++;
            @(negedge clk);
        end while (frame_start !== 1'b1 && len < 4 * FRAME);
    endtask

    // Hold valid/data until accepted, then drop valid.
    task automatic send(input logic [7:0] v);
        int unsigned n = 0;
        pos_data  = v;
        pos_valid = 1'b1;
        while (pos_ready !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pos_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: pos_ready=%b want 1 for data %0d", pos_ready, v);
        end
        @(posedge clk);
        @(negedge clk);
        pos_valid = 1'b0;
    endtask

    task automatic test_reset();
        int unsigned h, l;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (servo_pin !== 1'b0) begin errors++; $display("FAIL rst_pin: got %b want 0", servo_pin); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b want 0", frame_start); end
        checks++; if (active_pos !== 8'd128) begin errors++; $display("FAIL rst_pos: got %0d want 128", active_pos); end
        checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", pos_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rel_fs: got %b want 1", frame_start); end
        checks++; if (servo_pin !== 1'b1) begin errors++; $display("FAIL rel_pin: got %b want 1", servo_pin); end
        measure(h, l);
        checks++; if (h !== 684) begin errors++; $display("FAIL rel_high: got %0d want 684", h); end
        checks++; if (l !== 2000) begin errors++; $display("FAIL rel_period: got %0d want 2000", l); end
    endtask

    task automatic test_enable();
        int unsigned h0, l0, h1, l1, h2, l2;
        sync_frame();
        fork
            begin
                measure(h0, l0);
                measure(h1, l1);
                measure(h2, l2);
            end
            begin
                repeat (100) @(negedge clk);
                en = 1'b0;
                repeat (FRAME) @(negedge clk);
                en = 1'b1;
            end
        join
        checks++; if (h0 !== 684) begin errors++; $display("FAIL en_complete: got %0d want 684", h0); end
        checks++; if (h1 !== 0) begin errors++; $display("FAIL en_off: got %0d want 0", h1); end
        checks++; if (l1 !== 2000) begin errors++; $display("FAIL en_period: got %0d want 2000", l1); end
        checks++; if (h2 !== 684) begin errors++; $display("FAIL en_resume: got %0d want 684", h2); end
    endtask

    task automatic test_cmd_midframe();
        int unsigned h0, l0, h1, l1;
        sync_frame();
        fork
            begin
                measure(h0, l0);
                checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_after: got %b want 1", pos_ready); end
                checks++; if (active_pos !== 8'd0) begin errors++; $display("FAIL cmd_pos: got %0d want 0", active_pos); end
                measure(h1, l1);
            end
            begin
                repeat (100) @(negedge clk);
                send(8'd0);
                checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_held: got %b want 0", pos_ready); end
            end
        join
        checks++; if (h0 !== 684) begin errors++; $display("FAIL cmd_cur_high: got %0d want 684", h0); end
        checks++; if (h1 !== 300) begin errors++; $display("FAIL cmd_new_high: got %0d want 300", h1); end
        checks++; if (l1 !== 2000) begin errors++; $display("FAIL cmd_period: got %0d want 2000", l1); end
    endtask

    task automatic test_burst();
        int unsigned h0, l0, h1, l1, h2, l2;
        int unsigned n;
        sync_frame();
        fork
            begin
                measure(h0, l0);
                measure(h1, l1);
                measure(h2, l2);
            end
            begin
                repeat (50) @(negedge clk);
                send(8'd255);
                pos_data  = 8'd10;
                pos_valid = 1'b1;
                repeat (5) @(negedge clk);
                checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL burst_held: got %b want 0", pos_ready); end
                n = 0;
                while (pos_ready !== 1'b1 && n < 3 * FRAME) begin
                    @(negedge clk);
                    n++;
                end
                checks++; if (active_pos !== 8'd255) begin errors++; $display("FAIL burst_first: got %0d want 255", active_pos); end
                @(posedge clk);
                @(negedge clk);
                pos_valid = 1'b0;
                checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL burst_second_taken: got %b want 0", pos_ready); end
            end
        join
        checks++; if (h0 !== 300) begin errors++; $display("FAIL burst_cur: got %0d want 300", h0); end
        checks++; if (h1 !== 1065) begin errors++; $display("FAIL burst_255: got %0d want 1065", h1); end
        checks++; if (h2 !== 330) begin errors++; $display("FAIL burst_10: got %0d want 330", h2); end
        checks++; if (active_pos !== 8'd10) begin errors++; $display("FAIL burst_pos: got %0d want 10", active_pos); end
    endtask

    task automatic test_boundary_xfer();
        int unsigned h0, l0, h1, l1;
        sync_frame();
        repeat (FRAME - 1) @(negedge clk);
        pos_data  = 8'd200;
        pos_valid = 1'b1;
        @(negedge clk);
        pos_valid = 1'b0;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL bnd_fs: got %b want 1", frame_start); end
        checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL bnd_pending: got %b want 0", pos_ready); end
        checks++; if (active_pos !== 8'd10) begin errors++; $display("FAIL bnd_old_pos: got %0d want 10", active_pos); end
        measure(h0, l0);
        checks++; if (active_pos !== 8'd200) begin errors++; $display("FAIL bnd_new_pos: got %0d want 200", active_pos); end
        measure(h1, l1);
        checks++; if (h0 !== 330) begin errors++; $display("FAIL bnd_old_high: got %0d want 330", h0); end
        checks++; if (h1 !== 900) begin errors++; $display("FAIL bnd_new_high: got %0d want 900", h1); end
    endtask

    task automatic test_reset_midpulse();
        int unsigned h, l;
        sync_frame();
        repeat (50) @(negedge clk);
        checks++; if (servo_pin !== 1'b1) begin errors++; $display("FAIL mid_pin_high: got %b want 1", servo_pin); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (servo_pin !== 1'b0) begin errors++; $display("FAIL mid_async_drop: got %b want 0", servo_pin); end
        @(negedge clk);
        checks++; if (active_pos !== 8'd128) begin errors++; $display("FAIL mid_rst_pos: got %0d want 128", active_pos); end
        checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", pos_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (servo_pin !== 1'b1) begin errors++; $display("FAIL mid_first_pin: got %b want 1", servo_pin); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_first_fs: got %b want 1", frame_start); end
        measure(h, l);
        checks++; if (h !== 684) begin errors++; $display("FAIL mid_first_high: got %0d want 684", h); end
    endtask

    task automatic test_slew();
        logic [7:0] exp_pos [4];
        int unsigned h, l;
`ifdef SERVO_SLEW_EN
        exp_pos = '{8'd132, 8'd136, 8'd140, 8'd140};
`else
        exp_pos = '{8'd140, 8'd140, 8'd140, 8'd140};
`endif
        sync_frame();
        checks++; if (active_pos !== 8'd128) begin errors++; $display("FAIL slew_start: got %0d want 128", active_pos); end
        send(8'd140);
        for (int k = 0; k < 4; k++) begin
            sync_frame();
            checks++;
            if (active_pos !== exp_pos[k]) begin
                errors++;
                $display("FAIL slew_frame%0d: got %0d want %0d", k, active_pos, exp_pos[k]);
            end
        end
        measure(h, l);
        checks++; if (h !== 720) begin errors++; $display("FAIL slew_high: got %0d want 720", h); end
    endtask

    initial begin
        test_reset();
        test_enable();
`ifndef SERVO_SLEW_EN
        test_cmd_midframe();
        test_burst();
        test_boundary_xfer();
`endif
        test_reset_midpulse();
        test_slew();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
